// File: rtl/fifo_level_pkg.sv
// ============================================================================
// Package : fifo_level_pkg
// Brief   : Shared sizing helpers, default thresholds and op encoding.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_level_pkg;

  localparam int c_DEFAULT_AFULL_MARGIN = 4;
  localparam int c_DEFAULT_AEMPTY_LEVEL = 4;

  // Encoded as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RDWR = 2'b11
  } fifo_op_e;

  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_level_sync_if.sv
// ============================================================================
// Interface : fifo_level_sync_if
// Brief     : Producer/consumer bus of fifo_level_sync.
// Config    : FIFO_LEVEL_ERR_EN adds errclr/overflow/underflow signals.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_level_sync_if
  import fifo_level_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 32
);
  logic                                  fifo_clear_i;
  logic                                  fifo_writeflag_i;
  logic [DATA_WIDTH-1:0]                 fifo_writedata_i;
  logic                                  fifo_readflag_i;
  logic [DATA_WIDTH-1:0]                 fifo_readdata_o;
  logic                                  fifo_readvalid_o;
  logic                                  fifo_fullflag_o;
  logic                                  fifo_emptyflag_o;
  logic                                  fifo_almostfull_o;
  logic                                  fifo_almostempty_o;
  logic [count_width(ADDRESS_WIDTH)-1:0] fifo_count_o;
`ifdef FIFO_LEVEL_ERR_EN
  logic                                  fifo_errclr_i;
  logic                                  fifo_overflow_o;
  logic                                  fifo_underflow_o;

  modport master (
    output fifo_clear_i, fifo_writeflag_i, fifo_writedata_i, fifo_readflag_i, fifo_errclr_i,
    input  fifo_readdata_o, fifo_readvalid_o, fifo_fullflag_o, fifo_emptyflag_o,
           fifo_almostfull_o, fifo_almostempty_o, fifo_count_o, fifo_overflow_o, fifo_underflow_o
  );
  modport slave (
    input  fifo_clear_i, fifo_writeflag_i, fifo_writedata_i, fifo_readflag_i, fifo_errclr_i,
    output fifo_readdata_o, fifo_readvalid_o, fifo_fullflag_o, fifo_emptyflag_o,
           fifo_almostfull_o, fifo_almostempty_o, fifo_count_o, fifo_overflow_o, fifo_underflow_o
  );
`else
  modport master (
    output fifo_clear_i, fifo_writeflag_i, fifo_writedata_i, fifo_readflag_i,
    input  fifo_readdata_o, fifo_readvalid_o, fifo_fullflag_o, fifo_emptyflag_o,
           fifo_almostfull_o, fifo_almostempty_o, fifo_count_o
  );
  modport slave (
    input  fifo_clear_i, fifo_writeflag_i, fifo_writedata_i, fifo_readflag_i,
    output fifo_readdata_o, fifo_readvalid_o, fifo_fullflag_o, fifo_emptyflag_o,
           fifo_almostfull_o, fifo_almostempty_o, fifo_count_o
  );
`endif

endinterface

`default_nettype wire

// File: rtl/fifo_level_ram.sv
// ============================================================================
// Module : fifo_level_ram
// Brief  : Simple dual-port RAM, one write port, registered read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_level_ram
  import fifo_level_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     fifo_clk_i,
  input  logic                     fifo_rst_i,
  input  logic                     wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     rd_en_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  localparam int c_DEPTH = depth_of(ADDRESS_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Array carries no reset so it maps onto block RAM.
  always_ff @(posedge fifo_clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register holds its word until the next accepted read.
  always_ff @(posedge fifo_clk_i or posedge fifo_rst_i) begin
    if (fifo_rst_i) begin
      r_rd_data <= '0;
    end else if (rd_en_i) begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/fifo_level_sync.sv
// ============================================================================
// Module : fifo_level_sync
// Brief  : Single-clock FIFO with count, full/empty and almost thresholds.
// Config : FIFO_LEVEL_ERR_EN adds sticky overflow/underflow flags + errclr.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_level_sync
  import fifo_level_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 32,
  parameter int AFULL_LEVEL   = depth_of(ADDRESS_WIDTH) - c_DEFAULT_AFULL_MARGIN,
  parameter int AEMPTY_LEVEL  = c_DEFAULT_AEMPTY_LEVEL
) (
  input  logic             fifo_clk_i,
  input  logic             fifo_rst_i,
  fifo_level_sync_if.slave bus
);

  localparam int              c_DEPTH     = depth_of(ADDRESS_WIDTH);
  localparam int              c_CW        = count_width(ADDRESS_WIDTH);
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(c_DEPTH);
  localparam logic [c_CW-1:0] c_AFULL     = c_CW'(AFULL_LEVEL);
  localparam logic [c_CW-1:0] c_AEMPTY    = c_CW'(AEMPTY_LEVEL);

  logic [ADDRESS_WIDTH-1:0] r_wptr;
  logic [ADDRESS_WIDTH-1:0] r_rptr;
  logic [c_CW-1:0]          r_count;
  logic [c_CW-1:0]          w_count_next;
  logic                     r_full;
  logic                     r_empty;
  logic                     r_afull;
  logic                     r_aempty;
  logic                     r_rvalid;
  logic                     w_wr_en;
  logic                     w_rd_en;
  fifo_op_e                 w_op;
  logic [DATA_WIDTH-1:0]    w_rd_data;

  // Clear dominates, so an accepted request in a clear cycle never commits.
  assign w_wr_en = bus.fifo_writeflag_i & ~r_full  & ~bus.fifo_clear_i;
  assign w_rd_en = bus.fifo_readflag_i  & ~r_empty & ~bus.fifo_clear_i;
  assign w_op    = fifo_op_e'({w_wr_en, w_rd_en});

  always_comb begin
    w_count_next = r_count;
    if (bus.fifo_clear_i) begin
      w_count_next = '0;
    end else begin
      case (w_op)
        OP_WR:   w_count_next = r_count + c_CW'(1);
        OP_RD:   w_count_next = r_count - c_CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge fifo_clk_i or posedge fifo_rst_i) begin
    if (fifo_rst_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_rvalid <= 1'b0;
    end else begin
      if (bus.fifo_clear_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_en) r_wptr <= r_wptr + ADDRESS_WIDTH'(1);
        if (w_rd_en) r_rptr <= r_rptr + ADDRESS_WIDTH'(1);
      end
      // Status flags are registered from the next count so they track it exactly.
      r_count  <= w_count_next;
      r_full   <= (w_count_next == c_DEPTH_CNT);
      r_empty  <= (w_count_next == '0);
      r_afull  <= (w_count_next >= c_AFULL);
      r_aempty <= (w_count_next <= c_AEMPTY);
      r_rvalid <= w_rd_en;
    end
  end

  fifo_level_ram #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .fifo_clk_i (fifo_clk_i),
    .fifo_rst_i (fifo_rst_i),
    .wr_en_i    (w_wr_en),
    .wr_addr_i  (r_wptr),
    .wr_data_i  (bus.fifo_writedata_i),
    .rd_en_i    (w_rd_en),
    .rd_addr_i  (r_rptr),
    .rd_data_o  (w_rd_data)
  );

  assign bus.fifo_readdata_o    = w_rd_data;
  assign bus.fifo_readvalid_o   = r_rvalid;
  assign bus.fifo_fullflag_o    = r_full;
  assign bus.fifo_emptyflag_o   = r_empty;
  assign bus.fifo_almostfull_o  = r_afull;
  assign bus.fifo_almostempty_o = r_aempty;
  assign bus.fifo_count_o       = r_count;

`ifdef FIFO_LEVEL_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky; a new error in the errclr cycle wins over the clear.
  always_ff @(posedge fifo_clk_i or posedge fifo_rst_i) begin
    if (fifo_rst_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.fifo_writeflag_i && r_full) begin
        r_overflow <= 1'b1;
      end else if (bus.fifo_errclr_i) begin
        r_overflow <= 1'b0;
      end
      if (bus.fifo_readflag_i && r_empty) begin
        r_underflow <= 1'b1;
      end else if (bus.fifo_errclr_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.fifo_overflow_o  = r_overflow;
  assign bus.fifo_underflow_o = r_underflow;
`else
`endif

endmodule

`default_nettype wire
